// File: rtl/d_e_pipe_reg.sv
// ---------------------------------------------------------------------------
// d_e_pipe_reg
//
// ID/EX pipeline register of the 5-stage MIPS pipeline. Each rising edge either
// advances the D-stage bundle into E, or injects a NOP bubble when the stall
// unit asserts Stall. The block also keeps saturating stall statistics.
//
// Flow control: there is no valid/ready pair here. Stall is a one-cycle
// "hold upstream" command sampled on the rising edge:
//   - Stall=0: the D bundle is accepted and becomes the E bundle (E_Valid=1).
//   - Stall=1: the D bundle is NOT consumed; a bubble (E_Valid=0) enters E
//     carrying the stalled instruction's PC. The stall unit keeps D steady.
//
// Ports
//   clk          in   1      pipeline clock, rising-edge updates
//   reset        in   1      synchronous, active-high, overrides everything
//   Stall        in   1      1 = bubble into E this edge
//   D_Instr      in   32     instruction in D
//   D_PC         in   32     PC of D_Instr
//   D_RD1        in   32     forwarded rs value
//   D_RD2        in   32     forwarded rt value
//   D_Ext        in   32     extended immediate
//   D_Tnew       in   2      cycles until result ready (0..2; 3 is illegal
//                            and is registered unchanged)
//   E_Instr      out  32     registered instruction (0 = bubble)
//   E_PC         out  32     registered PC
//   E_RD1        out  32     registered rs value
//   E_RD2        out  32     registered rt value
//   E_Ext        out  32     registered immediate
//   E_Tnew       out  2      registered Tnew (0 for bubble)
//   E_Valid      out  1      1 = real instruction in E
//   stall_cycles out  CNT_W  total stalled edges since reset, saturating
//   stall_run    out  CNT_W  current consecutive stall run, saturating;
//                            doubles as the state: 0 = RUN, >0 = STALLING
//   stall_max    out  CNT_W  longest run seen (includes a live run), saturating
// ---------------------------------------------------------------------------
module d_e_pipe_reg #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic [31:0]      D_Instr,
    input  logic [31:0]      D_PC,
    input  logic [31:0]      D_RD1,
    input  logic [31:0]      D_RD2,
    input  logic [31:0]      D_Ext,
    input  logic [1:0]       D_Tnew,
    output logic [31:0]      E_Instr,
    output logic [31:0]      E_PC,
    output logic [31:0]      E_RD1,
    output logic [31:0]      E_RD2,
    output logic [31:0]      E_Ext,
    output logic [1:0]       E_Tnew,
    output logic             E_Valid,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] stall_run,
    output logic [CNT_W-1:0] stall_max
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rd1_q, rd1_d;
    logic [31:0]      rd2_q, rd2_d;
    logic [31:0]      ext_q, ext_d;
    logic [1:0]       tnew_q, tnew_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] max_q, max_d;

    // Pipeline bundle: advance or bubble.
    always_comb begin
        instr_d = D_Instr;
        pc_d    = D_PC;
        rd1_d   = D_RD1;
        rd2_d   = D_RD2;
        ext_d   = D_Ext;
        tnew_d  = D_Tnew;
        valid_d = 1'b1;
        if (Stall) begin
            // Bubble keeps the stalled instruction's PC so E_PC stays meaningful
            // for exception/debug reporting; everything else reads as a NOP.
            instr_d = 32'h0;
            rd1_d   = 32'h0;
            rd2_d   = 32'h0;
            ext_d   = 32'h0;
            tnew_d  = 2'd0;
            valid_d = 1'b0;
        end
    end

    // Stall statistics. run_q is the RUN/STALLING state: a non-stalled edge
    // returns to RUN (0); a stalled edge enters or stays in STALLING.
    always_comb begin
        cycles_d = cycles_q;
        run_d    = '0;
        max_d    = max_q;
        if (Stall) begin
            cycles_d = (cycles_q == CNT_SAT) ? CNT_SAT : cycles_q + CNT_ONE;
            run_d    = (run_q == CNT_SAT) ? CNT_SAT : run_q + CNT_ONE;
        end
        // Compare against the next run length so a live run is reflected
        // in stall_max on the same edge.
        if (run_d > max_q) begin
            max_d = run_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q  <= 32'h0;
            pc_q     <= PC_RESET;
            rd1_q    <= 32'h0;
            rd2_q    <= 32'h0;
            ext_q    <= 32'h0;
            tnew_q   <= 2'd0;
            valid_q  <= 1'b0;
            cycles_q <= '0;
            run_q    <= '0;
            max_q    <= '0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            ext_q    <= ext_d;
            tnew_q   <= tnew_d;
            valid_q  <= valid_d;
            cycles_q <= cycles_d;
            run_q    <= run_d;
            max_q    <= max_d;
        end
    end

    assign E_Instr      = instr_q;
    assign E_PC         = pc_q;
    assign E_RD1        = rd1_q;
    assign E_RD2        = rd2_q;
    assign E_Ext        = ext_q;
    assign E_Tnew       = tnew_q;
    assign E_Valid      = valid_q;
    assign stall_cycles = cycles_q;
    assign stall_run    = run_q;
    assign stall_max    = max_q;

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_d_e_pipe_reg
//
// Directed bench for d_e_pipe_reg. A 32-bit-counter instance covers the
// pipeline behaviour; a CNT_W=4 instance covers counter saturation.
// ---------------------------------------------------------------------------
module tb_d_e_pipe_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s_reset;
  logic        stall;
  logic        s_stall;
  logic [31:0] d_instr, d_pc, d_rd1, d_rd2, d_ext;
  logic [1:0]  d_tnew;

  logic [31:0] e_instr, e_pc, e_rd1, e_rd2, e_ext;
  logic [1:0]  e_tnew;
  logic        e_valid;
  logic [31:0] st_cycles, st_run, st_max;

  logic [31:0] s_instr, s_pc, s_rd1, s_rd2, s_ext;
  logic [1:0]  s_tnew;
  logic        s_valid;
  logic [3:0]  s_cycles, s_run, s_max;

  d_e_pipe_reg dut (
    .clk(clk), .reset(reset), .Stall(stall),
    .D_Instr(d_instr), .D_PC(d_pc), .D_RD1(d_rd1), .D_RD2(d_rd2),
    .D_Ext(d_ext), .D_Tnew(d_tnew),
    .E_Instr(e_instr), .E_PC(e_pc), .E_RD1(e_rd1), .E_RD2(e_rd2),
    .E_Ext(e_ext), .E_Tnew(e_tnew), .E_Valid(e_valid),
    .stall_cycles(st_cycles), .stall_run(st_run), .stall_max(st_max)
  );

  d_e_pipe_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(s_reset), .Stall(s_stall),
    .D_Instr(d_instr), .D_PC(d_pc), .D_RD1(d_rd1), .D_RD2(d_rd2),
    .D_Ext(d_ext), .D_Tnew(d_tnew),
    .E_Instr(s_instr), .E_PC(s_pc), .E_RD1(s_rd1), .E_RD2(s_rd2),
    .E_Ext(s_ext), .E_Tnew(s_tnew), .E_Valid(s_valid),
    .stall_cycles(s_cycles), .stall_run(s_run), .stall_max(s_max)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply one D bundle, take one rising edge, sample 1ns later.
  task automatic step(input logic st, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic [31:0] ext, input logic [1:0] tnew);
    stall   = st;
    d_instr = instr;
    d_pc    = pc;
    d_rd1   = rd1;
    d_rd2   = rd2;
    d_ext   = ext;
    d_tnew  = tnew;
    if (tnew == 2'b11) $display("note: illegal D_Tnew=3 driven at %0t", $time);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int edges);
    reset = 1'b1;
    repeat (edges) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_counters(input string tag, input logic [31:0] c,
                              input logic [31:0] r, input logic [31:0] m);
    chk({tag, ".cycles"}, st_cycles, c);
    chk({tag, ".run"},    st_run,    r);
    chk({tag, ".max"},    st_max,    m);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [31:0] ADDU1 = 32'h0043_0821; // addu $1,$2,$3
  localparam logic [31:0] LW    = 32'h8C41_0000; // lw   $1,0($2)
  localparam logic [31:0] ADDU2 = 32'h0022_1821; // addu $3,$1,$2

  initial begin
    reset = 1'b1; s_reset = 1'b1;
    stall = 1'b0; s_stall = 1'b0;
    d_instr = '0; d_pc = '0; d_rd1 = '0; d_rd2 = '0; d_ext = '0; d_tnew = '0;

    // 1: reset for two edges
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; s_reset = 1'b0;
    chk("rst.instr", e_instr, 32'h0);
    chk("rst.pc",    e_pc,    32'h0000_3000);
    chk("rst.rd1",   e_rd1,   32'h0);
    chk("rst.rd2",   e_rd2,   32'h0);
    chk("rst.ext",   e_ext,   32'h0);
    chk("rst.tnew",  {30'b0, e_tnew}, 32'h0);
    chk("rst.valid", {31'b0, e_valid}, 32'h0);
    chk_counters("rst", 0, 0, 0);
    chk("rst.small_pc", s_pc, 32'h0000_3000);

    // 2: plain advance
    step(1'b0, ADDU1, 32'h3004, 32'h1111_0001, 32'h2222_0002, 32'h0000_FFF0, 2'd1);
    chk("adv.instr", e_instr, ADDU1);
    chk("adv.pc",    e_pc,    32'h3004);
    chk("adv.rd1",   e_rd1,   32'h1111_0001);
    chk("adv.rd2",   e_rd2,   32'h2222_0002);
    chk("adv.ext",   e_ext,   32'h0000_FFF0);
    chk("adv.tnew",  {30'b0, e_tnew}, 32'd1);
    chk("adv.valid", {31'b0, e_valid}, 32'd1);
    chk_counters("adv", 0, 0, 0);

    // 3: lw, then dependent addu stalled one edge, then advances
    step(1'b0, LW, 32'h3008, 32'h0000_0100, 32'h0, 32'h0, 2'd2);
    chk("lw.instr", e_instr, LW);
    chk("lw.tnew",  {30'b0, e_tnew}, 32'd2);
    step(1'b1, ADDU2, 32'h300C, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h1234, 2'd1);
    chk("bub.instr", e_instr, 32'h0);
    chk("bub.valid", {31'b0, e_valid}, 32'd0);
    chk("bub.pc",    e_pc,    32'h300C);
    chk("bub.rd1",   e_rd1,   32'h0);
    chk("bub.rd2",   e_rd2,   32'h0);
    chk("bub.ext",   e_ext,   32'h0);
    chk("bub.tnew",  {30'b0, e_tnew}, 32'd0);
    chk_counters("bub", 1, 1, 1);
    step(1'b0, ADDU2, 32'h300C, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h1234, 2'd1);
    chk("resume.instr", e_instr, ADDU2);
    chk("resume.valid", {31'b0, e_valid}, 32'd1);
    chk("resume.rd1",   e_rd1,   32'hAAAA_AAAA);
    chk_counters("resume", 1, 0, 1);

    // 4: stall pattern 1,1,1,0,1,1 from a fresh reset
    do_reset(1);
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    step(1'b1, ADDU1, 32'h3010, 32'h5, 32'h6, 32'h7, 2'd1);
    chk("pat.valid0", {31'b0, e_valid}, {31'b0, exp_q.pop_front()});
    step(1'b1, ADDU1, 32'h3010, 32'h5, 32'h6, 32'h7, 2'd1);
    chk("pat.valid1", {31'b0, e_valid}, {31'b0, exp_q.pop_front()});
    step(1'b1, ADDU1, 32'h3010, 32'h5, 32'h6, 32'h7, 2'd1);
    chk("pat.valid2", {31'b0, e_valid}, {31'b0, exp_q.pop_front()});
    chk_counters("pat.run3", 3, 3, 3);
    // illegal Tnew=3 on the advancing edge is registered unchanged
    step(1'b0, ADDU1, 32'h3010, 32'h5, 32'h6, 32'h7, 2'b11);
    chk("pat.valid3", {31'b0, e_valid}, {31'b0, exp_q.pop_front()});
    chk("pat.tnew3",  {30'b0, e_tnew}, 32'd3);
    chk_counters("pat.gap", 3, 0, 3);
    step(1'b1, ADDU2, 32'h3014, 32'h8, 32'h9, 32'hA, 2'd0);
    chk("pat.valid4", {31'b0, e_valid}, {31'b0, exp_q.pop_front()});
    step(1'b1, ADDU2, 32'h3014, 32'h8, 32'h9, 32'hA, 2'd0);
    chk("pat.valid5", {31'b0, e_valid}, {31'b0, exp_q.pop_front()});
    chk("pat.pc",     e_pc, 32'h3014);
    chk_counters("pat.end", 5, 2, 3);

    // 5: 4-bit counters saturate
    stall   = 1'b0;
    s_stall = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("sat.cycles14", {28'b0, s_cycles}, 32'hE);
    chk("sat.run14",    {28'b0, s_run},    32'hE);
    repeat (6) @(posedge clk);
    #1;
    chk("sat.cycles20", {28'b0, s_cycles}, 32'hF);
    chk("sat.run20",    {28'b0, s_run},    32'hF);
    chk("sat.max20",    {28'b0, s_max},    32'hF);
    s_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("sat.run_clr",  {28'b0, s_run},    32'h0);
    chk("sat.max_hold", {28'b0, s_max},    32'hF);
    chk("sat.cyc_hold", {28'b0, s_cycles}, 32'hF);

    // 6: reset on the second edge of a stall run
    step(1'b1, ADDU1, 32'h3020, 32'h1, 32'h2, 32'h3, 2'd1);
    chk("rstrun.run1", st_run, 32'd1);
    reset = 1'b1;
    step(1'b1, ADDU1, 32'h3020, 32'h1, 32'h2, 32'h3, 2'd1);
    reset = 1'b0;
    chk("rstrun.pc",    e_pc, 32'h0000_3000);
    chk("rstrun.valid", {31'b0, e_valid}, 32'd0);
    chk_counters("rstrun", 0, 0, 0);
    step(1'b0, ADDU1, 32'h3020, 32'h1, 32'h2, 32'h3, 2'd1);
    chk("rstrun.after", e_instr, ADDU1);
    chk_counters("rstrun.after", 0, 0, 0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
